block_stream_gen: RTL and testbench
===================================

// Module: block_stream_gen
// PURPOSE
//   Transmit-side counterpart of the begin/end block checker: turns word-level
//   commands into a serial ASCII character stream, one byte per handshake,
//   each word terminated by a space (0x20). Tracks the BEGIN/END nesting depth
//   of the emitted stream the same way the checker will count it. Used as a
//   stimulus source and loopback partner for the checker in system benches.
// PARAMETERS
//   DEPTH_W  32  width of the nesting-depth counter (saturates at 2^DEPTH_W-1)
// PORTS
//   clk        in   1        system clock; all state updates on posedge
//   reset      in   1        synchronous, active-high; sampled on posedge clk
//   cmd_valid  in   1        command present on cmd/upper
//   cmd        in   2        0=BEGIN, 1=END, 2=SPACE only, 3=JUNK word "x"
//   upper      in   1        1: emit letters uppercase, 0: lowercase
//   cmd_ready  out  1        block can accept a command this cycle
//   out        out  8        current ASCII character
//   out_valid  out  1        out holds a valid character
//   out_ready  in   1        sink accepts out this cycle
//   depth      out  DEPTH_W  open BEGINs not yet closed
//   balanced   out  1        depth==0 and no END was ever emitted at depth 0
// BEHAVIOUR
//   - One clock, clk. Reset is synchronous, active-high, on reset.
//   - Reset values: state=IDLE, out_valid=0, out=8'h00, cmd_ready=1,
//     depth=0, err=0, balanced=1. Reset mid-word aborts the word; no further
//     characters; no depth update for the aborted word.
//   - FSM: IDLE, EMIT, SEP.
//     IDLE: cmd_ready=1, out_valid=0. On cmd_valid&&cmd_ready, latch cmd and
//       upper; clear idx. cmd 0/1/3 -> EMIT; cmd 2 -> SEP.
//     EMIT: out_valid=1, out=char(cmd,idx,upper). On out_ready: if idx is the
//       last index -> SEP, else idx+1.
//     SEP: out_valid=1, out=8'h20. On out_ready: apply depth update -> IDLE.
//   - cmd_ready=1 only in IDLE. Commands presented in EMIT/SEP are not
//     accepted; cmd_valid must stay high until accepted.
//   - Words: BEGIN "begin"/"BEGIN" (62 65 67 69 6E / 42 45 47 49 4E),
//     END "end"/"END" (65 6E 64 / 45 4E 44), JUNK "x"/"X" (78 / 58).
//   - Latency: command accepted at edge N -> first char valid in cycle N+1.
//     With out_ready held at 1, one char per cycle and no gaps within a word.
//     Next command can be accepted in the cycle after the space is taken.
//   - out and out_valid are decoded from registered state/idx only; there is
//     no combinational path from out_ready or cmd_valid to out/out_valid.
//     While out_valid=1 and out_ready=0, out stays stable.
//   - Depth update occurs on the space handshake only.
//     BEGIN: depth+1, saturating at all-ones.
//     END at depth>0: depth-1.
//     END at depth==0: depth stays 0; sticky err=1 until reset.
//     SPACE or JUNK: no change.
//   - balanced = (depth==0) && !err, combinational from registers.
// TESTING
//   1 reset; BEGIN, upper=0, out_ready=1 -> out 62,65,67,69,6E,20 on cycles
//     N+1..N+6; depth=1, balanced=0 after N+6
//   2 then END, upper=1 -> 45,4E,44,20; depth=0, balanced=1
//   3 END at depth 0 -> 65,6E,64,20; depth=0, balanced=0 and stays 0 after a
//     later BEGIN+END pair; reset restores balanced=1
//   4 BEGIN with out_ready=0 for 3 cycles while out=67 -> out held at 67,
//     out_valid=1; cmd_ready=0 and a second cmd_valid is not accepted
//   5 reset asserted while out=69 -> next cycle out_valid=0, depth=0,
//     cmd_ready=1; no 6E/20 emitted
//   6 DEPTH_W=2: four BEGINs -> depth 1,2,3,3 (saturated); SPACE cmd -> single
//     20; JUNK upper=1 -> 58,20; depth unchanged by SPACE/JUNK

Source files
------------

// File: rtl/block_stream_gen.sv
// Serial ASCII word generator: expands BEGIN/END/SPACE/JUNK commands into
// space-terminated characters and tracks the resulting BEGIN/END nesting depth.
module block_stream_gen #(
  parameter int unsigned DEPTH_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd,
  input  logic               upper,
  output logic               cmd_ready,
  output logic [7:0]         out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DEPTH_W-1:0] depth,
  output logic               balanced
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    SEP  = 2'd2
  } state_e;

  localparam logic [1:0] CMD_BEGIN = 2'd0;
  localparam logic [1:0] CMD_END   = 2'd1;
  localparam logic [1:0] CMD_SPACE = 2'd2;
  localparam logic [1:0] CMD_JUNK  = 2'd3;

  state_e             state_q, state_d;
  logic [1:0]         cmd_q, cmd_d;
  logic               upper_q, upper_d;
  logic [2:0]         idx_q, idx_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               err_q, err_d;

  // Letters are stored lowercase; clearing bit 5 gives the uppercase form.
  function automatic logic [7:0] word_char(input logic [1:0] c, input logic [2:0] i,
                                           input logic up);
    logic [7:0] lc;
    lc = 8'h00;
    case (c)
      CMD_BEGIN: begin
        case (i)
          3'd0:    lc = 8'h62;
          3'd1:    lc = 8'h65;
          3'd2:    lc = 8'h67;
          3'd3:    lc = 8'h69;
          3'd4:    lc = 8'h6E;
          default: lc = 8'h00;
        endcase
      end
      CMD_END: begin
        case (i)
          3'd0:    lc = 8'h65;
          3'd1:    lc = 8'h6E;
          3'd2:    lc = 8'h64;
          default: lc = 8'h00;
        endcase
      end
      CMD_JUNK: lc = 8'h78;
      default:  lc = 8'h00;
    endcase
    if (up) begin
      return lc & 8'hDF;
    end else begin
      return lc;
    end
  endfunction

  function automatic logic [2:0] last_idx(input logic [1:0] c);
    case (c)
      CMD_BEGIN: return 3'd4;
      CMD_END:   return 3'd2;
      default:   return 3'd0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cmd_q   <= 2'd0;
      upper_q <= 1'b0;
      idx_q   <= 3'd0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      upper_q <= upper_d;
      idx_q   <= idx_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    upper_d = upper_q;
    idx_d   = idx_q;
    depth_d = depth_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_d   = cmd;
          upper_d = upper;
          idx_d   = 3'd0;
          state_d = (cmd == CMD_SPACE) ? SEP : EMIT;
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (idx_q == last_idx(cmd_q)) begin
            state_d = SEP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          state_d = EMIT;
        end
      end
      SEP: begin
        // Depth only moves when the terminating space is handed off.
        if (out_ready) begin
          state_d = IDLE;
          case (cmd_q)
            CMD_BEGIN: begin
              if (depth_q != '1) begin
                depth_d = depth_q + DEPTH_W'(1);
              end else begin
                depth_d = depth_q;
              end
            end
            CMD_END: begin
              if (depth_q != '0) begin
                depth_d = depth_q - DEPTH_W'(1);
              end else begin
                err_d = 1'b1;
              end
            end
            default: depth_d = depth_q;
          endcase
        end else begin
          state_d = SEP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    out_valid = (state_q != IDLE);
    case (state_q)
      EMIT:    out = word_char(cmd_q, idx_q, upper_q);
      SEP:     out = 8'h20;
      default: out = 8'h00;
    endcase
    depth    = depth_q;
    balanced = (depth_q == '0) && !err_q;
  end

endmodule

// File: tb/tb_block_stream_gen.sv
// Scoreboard bench for block_stream_gen: expected characters are queued from
// word strings on command acceptance and popped by a monitor on each handshake.
module tb_block_stream_gen;
  localparam int DW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic [1:0]    cmd;
  logic          upper;
  logic          cmd_ready;
  logic [7:0]    out;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] depth;
  logic          balanced;

  block_stream_gen #(.DEPTH_W(DW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .upper(upper),
    .cmd_ready(cmd_ready), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .depth(depth), .balanced(balanced)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] ch;
    logic [1:0] eff;  // 0 none, 1 open, 2 close (only on the space)
  } item_t;

  item_t      exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         m_depth = 0;
  bit         m_err = 1'b0;
  bit         mon_en = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_out;
  int         rdy_mode = 0;
  int         stall_req = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [1:0] c, input bit up);
    string w;
    item_t it;
    case (c)
      2'd0:    w = "begin";
      2'd1:    w = "end";
      2'd3:    w = "x";
      default: w = "";
    endcase
    if (up) w = w.toupper();
    for (int i = 0; i < w.len(); i++) begin
      it.ch = w[i];
      it.eff = 2'd0;
      exp_q.push_back(it);
    end
    it.ch = 8'h20;
    it.eff = (c == 2'd0) ? 2'd1 : ((c == 2'd1) ? 2'd2 : 2'd0);
    exp_q.push_back(it);
  endtask

  // Monitor: compare first, then advance the model for the coming edge.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("cmd_ready", 64'(cmd_ready), 64'(exp_q.size() == 0));
        chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() == 0) chk("idle_out", 64'(out), 64'h00);
        chk("depth", 64'(depth), 64'(m_depth));
        chk("balanced", 64'(balanced), 64'(m_depth == 0 && !m_err));
        if (prev_stall) begin
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_hold", 64'(out), 64'(prev_out));
        end
        prev_stall = 1'b0;
        if (reset) begin
          exp_q.delete();
          m_depth = 0;
          m_err = 1'b0;
        end else begin
          if (out_valid && out_ready && exp_q.size() != 0) begin
            it = exp_q.pop_front();
            chk("char", 64'(out), 64'(it.ch));
            if (it.eff == 2'd1 && m_depth < (1 << DW) - 1) m_depth++;
            if (it.eff == 2'd2) begin
              if (m_depth > 0) m_depth--;
              else m_err = 1'b1;
            end
          end else if (out_valid && !out_ready) begin
            prev_stall = 1'b1;
            prev_out = out;
          end
          if (cmd_valid && cmd_ready) push_word(cmd, upper);
        end
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_req > 0) begin
        out_ready = 1'b0;
        stall_req--;
      end else if (rdy_mode == 1) begin
        out_ready = ($urandom % 3) != 0;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  task automatic send(input logic [1:0] c, input bit up);
    int n;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd = c;
    upper = up;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 300);
    chk("accept_timeout", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_out(input logic [7:0] v);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out == v) && n < 100);
    chk("wait_out", 64'(out), 64'(v));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_q.size() == 0 && cmd_ready) && n < 500);
    chk("idle_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd = 2'd0;
    upper = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;

    // Nesting, uppercase END, END at depth 0 with sticky error.
    send(2'd0, 1'b0);
    send(2'd1, 1'b1);
    wait_idle();
    send(2'd1, 1'b0);
    send(2'd0, 1'b0);
    send(2'd1, 1'b0);
    wait_idle();
    do_reset();

    // Backpressure on 'g' while a second command waits.
    fork
      send(2'd0, 1'b0);
      begin
        wait_out(8'h65);
        stall_req = 3;
      end
    join
    send(2'd3, 1'b1);
    wait_idle();

    // Reset during the 'i' of BEGIN aborts the word.
    send(2'd0, 1'b0);
    wait_out(8'h67);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_idle();

    // Saturation, then SPACE and JUNK leave depth alone.
    repeat (4) send(2'd0, 1'b1);
    send(2'd2, 1'b0);
    send(2'd3, 1'b1);
    wait_idle();
    do_reset();

    rdy_mode = 1;
    for (int k = 0; k < 250; k++) begin
      send(2'($urandom % 4), 1'($urandom % 2));
      if (($urandom % 40) == 0) begin
        repeat ($urandom % 6) @(posedge clk);
        do_reset();
      end
    end
    rdy_mode = 0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
